distance_filter: RTL and testbench
==================================

# distance_filter

Post-processing stage directly downstream of the ultrasonic distance reader. It accepts each new distance sample, clamps out-of-range values, and keeps a 4-sample sliding-window average. From that average it produces a hysteretic obstacle flag for the motion controller. A watchdog flags stale data when the sensor stops delivering samples, and the obstacle output fails safe (asserted) while data is missing or stale.

## Interface
- N_WIDTH, 17: width of distance sample and average (reader units).
- MAX_DIST, 400: clamp ceiling; samples above are replaced by MAX_DIST.
- NEAR_TH, 20: average strictly below this sets obstacle. Constraint: NEAR_TH <= FAR_TH.
- FAR_TH, 30: average strictly above this clears obstacle.
- TIMEOUT_CYCLES, 3000000: cycles without a sample before STALE (60 ms @ 50 MHz).
- TW, 22: watchdog counter width. Must hold TIMEOUT_CYCLES.
- Clock and reset: one clock; reset is synchronous and active-high.
- DISTANCE_FILTER_CLOCK_50 in 1: system clock, all logic on rising edge.
- DISTANCE_FILTER_RESET_InHigh in 1: synchronous reset, active-high.
- DISTANCE_FILTER_DISTANCE_InBus in N_WIDTH: distance from reader, meaningful only when VALID_In=1.
- DISTANCE_FILTER_VALID_In in 1: one-cycle strobe, new sample present. May be high on consecutive cycles.
- DISTANCE_FILTER_AVERAGE_OutBus out N_WIDTH: registered window average.
- DISTANCE_FILTER_VALID_Out out 1: one-cycle strobe, AVERAGE updated.
- DISTANCE_FILTER_READY_Out out 1: window holds 4 samples since reset.
- DISTANCE_FILTER_OBSTACLE_Out out 1: stop request = ~READY | obstacle_reg | STALE.
- DISTANCE_FILTER_STALE_Out out 1: watchdog expired.

## Operation
- **Stage 0 (clamp).** On a cycle with VALID_In=1, sample s = min(DISTANCE_InBus, MAX_DIST) is registered with a valid bit.
- **Stage 1 (window).**
  - 4-entry shift buffer w0..w3; s enters at w0 and w3 is discarded.
  - Running sum (N_WIDTH+2 bits) updates as sum <= sum + s - w3, using the pre-shift w3.
  - fill counter (0..4) increments per sample and saturates at 4.
- **Stage 2 (output).**
  - AVERAGE <= sum[N_WIDTH+1:2], i.e. floor(sum/4).
  - VALID_Out pulses. READY = (fill==4).
- **Warm-up.** The buffer resets to 0. Before fill==4, AVERAGE still updates as sum/4 over the zero-padded window, but READY=0 and OBSTACLE is forced to 1.
- **Hysteresis.** Applies on each stage-2 update where fill==4:
  - avg < NEAR_TH: obstacle_reg <= 1.
  - avg > FAR_TH: obstacle_reg <= 0.
  - Otherwise: hold.
- **Watchdog.**
  - Cycle with VALID_In=1: timer <= 0.
  - Otherwise: timer <= timer+1, saturating at TIMEOUT_CYCLES.
  - STALE_Out = (timer == TIMEOUT_CYCLES).
  - Stale data does not alter the buffer or obstacle_reg.
- **Reset.** Clears the buffer, sum, fill, pipeline valids, AVERAGE, obstacle_reg and timer on the next edge. Reset takes priority over VALID_In in the same cycle, and a sample in flight is dropped.

## Timing
- **Reset values:**
  - AVERAGE_OutBus = 0
  - VALID_Out = 0
  - READY_Out = 0
  - STALE_Out = 0
  - OBSTACLE_Out = 1, via ~READY.
- **Latency.** VALID_In sampled at edge k causes VALID_Out high after edge k+2, with the matching AVERAGE and OBSTACLE at the same time.
- **Throughput.** One sample per cycle, fully pipelined, no backpressure, no sample loss.
- **READY.** Rises together with the VALID_Out of the 4th sample and stays high until reset.
- **STALE rise.** Rises TIMEOUT_CYCLES edges after the edge that sampled the last VALID_In. After reset it rises TIMEOUT_CYCLES edges after reset is released.
- **STALE clear.** Falls on the edge that samples the next VALID_In, so it is 0 in the following cycle, 2 cycles before that sample's VALID_Out.
- **Saturation.** Sum max 4*MAX_DIST, which fits N_WIDTH+2 bits. The timer never wraps.

## Test plan
- **Reset / warm-up.** Hold reset 3 cycles, release, then send samples 100,100,100,100 → expected:
  - Reset values as listed while reset is held.
  - AVERAGE 25,50,75,100, each 2 cycles after its strobe.
  - READY=1 and OBSTACLE=0 with the 4th VALID_Out.
- **Hysteresis.** After the fill above:
  - 10 ×4 → AVERAGE 77,55,32,10; OBSTACLE rises only at 10.
  - Then 25 ×4 → 13,17,21,25; OBSTACLE stays 1.
  - Then 40 ×2 → 28,32; OBSTACLE clears at 32.
- **Clamp.** Samples 5000 ×4 after a fill of 0s → AVERAGE 100,200,300,400; never above 400.
- **Back-to-back.** VALID_In high 8 consecutive cycles with 1..8 → 8 consecutive VALID_Out, last AVERAGE = floor(26/4) = 6.
- **Watchdog.** With TIMEOUT_CYCLES=100, no strobe → STALE=1 exactly 100 edges after the last sample and OBSTACLE=1. The next strobe → STALE=0 one cycle later.
- **Reset mid-operation.** Assert reset on the same cycle as VALID_In=1 → no VALID_Out follows, and READY=0, AVERAGE=0, OBSTACLE=1.

Source files
------------

// File: rtl/distance_filter.sv
// distance_filter: clamps incoming distance samples, averages the last four
// of them, and derives a hysteretic obstacle flag. A watchdog reports stale
// data. The obstacle output is forced high while the window is not yet
// full or the data is stale.
module distance_filter #(
  parameter int N_WIDTH        = 17,
  parameter int MAX_DIST       = 400,
  parameter int NEAR_TH        = 20,
  parameter int FAR_TH         = 30,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int TW             = 22
) (
  input  logic               DISTANCE_FILTER_CLOCK_50,
  input  logic               DISTANCE_FILTER_RESET_InHigh,
  input  logic [N_WIDTH-1:0] DISTANCE_FILTER_DISTANCE_InBus,
  input  logic               DISTANCE_FILTER_VALID_In,
  output logic [N_WIDTH-1:0] DISTANCE_FILTER_AVERAGE_OutBus,
  output logic               DISTANCE_FILTER_VALID_Out,
  output logic               DISTANCE_FILTER_READY_Out,
  output logic               DISTANCE_FILTER_OBSTACLE_Out,
  output logic               DISTANCE_FILTER_STALE_Out
);

  localparam int SW = N_WIDTH + 2;
  localparam logic [N_WIDTH-1:0] MAX_D  = N_WIDTH'(MAX_DIST);
  localparam logic [N_WIDTH-1:0] NEAR_D = N_WIDTH'(NEAR_TH);
  localparam logic [N_WIDTH-1:0] FAR_D  = N_WIDTH'(FAR_TH);
  localparam logic [TW-1:0]      TO_D   = TW'(TIMEOUT_CYCLES);

  logic                    clk, rst;
  assign clk = DISTANCE_FILTER_CLOCK_50;
  assign rst = DISTANCE_FILTER_RESET_InHigh;

  // stage 0
  logic                    v0_q;
  logic [N_WIDTH-1:0]      s0_q, s_clamp;
  // stage 1
  logic                    v1_q;
  logic [3:0][N_WIDTH-1:0] win_q;
  logic [SW-1:0]           sum_q, sum_d;
  logic [2:0]              fill_q, fill_d;
  // stage 2
  logic                    vout_q, ready_q, obst_q, obst_d;
  logic [N_WIDTH-1:0]      avg_q, avg_d;
  // watchdog
  logic [TW-1:0]           timer_q, timer_d;

  // Next-state logic for clamp, window sum, fill, hysteresis and watchdog.
  always_comb begin
    s_clamp = (DISTANCE_FILTER_DISTANCE_InBus > MAX_D) ? MAX_D
                                                       : DISTANCE_FILTER_DISTANCE_InBus;
    // Modular arithmetic is exact here: the true result is never negative.
    sum_d   = sum_q + {2'b00, s0_q} - {2'b00, win_q[3]};
    fill_d  = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    avg_d   = sum_q[SW-1:2];
    obst_d  = obst_q;
    if (fill_q == 3'd4) begin
      if (avg_d < NEAR_D)     obst_d = 1'b1;
      else if (avg_d > FAR_D) obst_d = 1'b0;
    end
    timer_d = timer_q;
    if (DISTANCE_FILTER_VALID_In) timer_d = '0;
    else if (timer_q != TO_D)     timer_d = timer_q + 1'b1;
  end

  // Three-stage pipeline plus watchdog timer; reset wins over a new sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      s0_q    <= '0;
      v1_q    <= 1'b0;
      win_q   <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      vout_q  <= 1'b0;
      avg_q   <= '0;
      ready_q <= 1'b0;
      obst_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      v0_q <= DISTANCE_FILTER_VALID_In;
      if (DISTANCE_FILTER_VALID_In) s0_q <= s_clamp;
      v1_q <= v0_q;
      if (v0_q) begin
        win_q  <= {win_q[2:0], s0_q};
        sum_q  <= sum_d;
        fill_q <= fill_d;
      end
      vout_q <= v1_q;
      if (v1_q) begin
        avg_q   <= avg_d;
        ready_q <= (fill_q == 3'd4);
        obst_q  <= obst_d;
      end
      timer_q <= timer_d;
    end
  end

  assign DISTANCE_FILTER_AVERAGE_OutBus = avg_q;
  assign DISTANCE_FILTER_VALID_Out      = vout_q;
  assign DISTANCE_FILTER_READY_Out      = ready_q;
  assign DISTANCE_FILTER_STALE_Out      = (timer_q == TO_D);
  assign DISTANCE_FILTER_OBSTACLE_Out   = ~ready_q | obst_q | DISTANCE_FILTER_STALE_Out;

endmodule

// File: tb/tb_distance_filter.sv
// Directed bench for distance_filter with hand-computed expected values.
module tb_distance_filter;

  localparam int NW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NW-1:0] din = '0;
  logic          vin = 1'b0;
  logic [NW-1:0] avg;
  logic          vout, rdy, obst, stale;

  int total = 0;
  int bad   = 0;

  distance_filter #(.TIMEOUT_CYCLES(100)) dut (
    .DISTANCE_FILTER_CLOCK_50      (clk),
    .DISTANCE_FILTER_RESET_InHigh  (rst),
    .DISTANCE_FILTER_DISTANCE_InBus(din),
    .DISTANCE_FILTER_VALID_In      (vin),
    .DISTANCE_FILTER_AVERAGE_OutBus(avg),
    .DISTANCE_FILTER_VALID_Out     (vout),
    .DISTANCE_FILTER_READY_Out     (rdy),
    .DISTANCE_FILTER_OBSTACLE_Out  (obst),
    .DISTANCE_FILTER_STALE_Out     (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample; check the result two edges after it is sampled.
  task automatic send_chk(input logic [NW-1:0] d, input int ea, input logic eo, input logic er);
    vin = 1'b1; din = d;
    tick();
    vin = 1'b0;
    tick();
    chk("early_vout", 32'(vout), 0);
    tick();
    chk("vout", 32'(vout), 1);
    chk("avg", 32'(avg), 32'(ea));
    chk("obst", 32'(obst), 32'(eo));
    chk("ready", 32'(rdy), 32'(er));
  endtask

  int b2b_exp [8] = '{300, 200, 101, 2, 3, 4, 5, 6};

  initial begin
    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_avg", 32'(avg), 0);
      chk("rst_vout", 32'(vout), 0);
      chk("rst_ready", 32'(rdy), 0);
      chk("rst_stale", 32'(stale), 0);
      chk("rst_obst", 32'(obst), 1);
    end
    rst = 1'b0;

    // warm-up
    send_chk(100, 25, 1, 0);
    send_chk(100, 50, 1, 0);
    send_chk(100, 75, 1, 0);
    send_chk(100, 100, 0, 1);

    // hysteresis
    send_chk(10, 77, 0, 1);
    send_chk(10, 55, 0, 1);
    send_chk(10, 32, 0, 1);
    send_chk(10, 10, 1, 1);
    send_chk(25, 13, 1, 1);
    send_chk(25, 17, 1, 1);
    send_chk(25, 21, 1, 1);
    send_chk(25, 25, 1, 1);
    send_chk(40, 28, 1, 1);
    send_chk(40, 32, 0, 1);

    // fill with zeros, then clamp
    send_chk(0, 26, 0, 1);
    send_chk(0, 20, 0, 1);
    send_chk(0, 10, 1, 1);
    send_chk(0, 0, 1, 1);
    send_chk(5000, 100, 0, 1);
    send_chk(5000, 200, 0, 1);
    send_chk(5000, 300, 0, 1);
    send_chk(5000, 400, 0, 1);

    // back-to-back 1..8
    for (int i = 0; i < 10; i++) begin
      vin = (i < 8);
      din = NW'(i + 1);
      tick();
      if (i >= 2) begin
        chk("b2b_vout", 32'(vout), 1);
        chk("b2b_avg", 32'(avg), 32'(b2b_exp[i-2]));
      end
    end
    vin = 1'b0;
    tick();
    chk("b2b_tail", 32'(vout), 0);

    // watchdog
    vin = 1'b1; din = 50;
    tick();
    vin = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("stale_99", 32'(stale), 0);
    tick();
    chk("stale_100", 32'(stale), 1);
    chk("stale_obst", 32'(obst), 1);
    repeat (5) tick();
    chk("stale_hold", 32'(stale), 1);
    vin = 1'b1; din = 50;
    tick();
    vin = 1'b0;
    chk("stale_clr", 32'(stale), 0);
    repeat (3) tick();

    // reset colliding with a sample
    vin = 1'b1; din = 200; rst = 1'b1;
    tick();
    vin = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid_vout", 32'(vout), 0);
      tick();
    end
    chk("mid_ready", 32'(rdy), 0);
    chk("mid_avg", 32'(avg), 0);
    chk("mid_obst", 32'(obst), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
